// File: rtl/atpg_response_checker.sv
// atpg_response_checker: compares fault-injected vs golden response beats, counts mismatches and MISR-compacts dut_y
module atpg_response_checker #(
    parameter int N_OUT = 1,
    parameter int CNT_W = 16,
    parameter int MISR_W = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_pat_valid,
    input  logic              i_pat_last,
    input  logic [N_OUT-1:0]  i_dut_y,
    input  logic [N_OUT-1:0]  i_gold_y,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [CNT_W-1:0]  o_pat_cnt,
    output logic [CNT_W-1:0]  o_mismatch_cnt,
    output logic [CNT_W-1:0]  o_first_fail_idx,
    output logic [MISR_W-1:0] o_signature
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [1:0]        r_state;
    logic              r_fail;
    logic [CNT_W-1:0]  r_pat_cnt;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic [CNT_W-1:0]  r_ff_idx;
    logic [MISR_W-1:0] r_sig;
    logic              w_clear;
    logic              w_beat;
    logic              w_mis;
    logic [MISR_W-1:0] w_sig_next;
    assign w_clear = (r_state != S_RUN) && i_start;
    assign w_beat = (r_state == S_RUN) && i_pat_valid;
    assign w_mis = i_dut_y != i_gold_y;
    assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0} ^ (r_sig[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(i_dut_y);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fail <= 1'b0;
            r_pat_cnt <= '0;
            r_mis_cnt <= '0;
            r_ff_idx <= '0;
            r_sig <= '0;
        end else if (w_clear) begin
            r_state <= S_RUN;
            r_fail <= 1'b0;
            r_pat_cnt <= '0;
            r_mis_cnt <= '0;
            r_ff_idx <= '0;
            r_sig <= MISR_SEED;
        end else if (w_beat) begin
            r_pat_cnt <= (r_pat_cnt == CNT_MAX) ? r_pat_cnt : r_pat_cnt + 1'b1;
            r_sig <= w_sig_next;
            if (w_mis) begin
                r_mis_cnt <= (r_mis_cnt == CNT_MAX) ? r_mis_cnt : r_mis_cnt + 1'b1;
                r_fail <= 1'b1;
                if (!r_fail) r_ff_idx <= r_pat_cnt;
            end
            if (i_pat_last) r_state <= S_DONE;
        end
    end
    assign o_busy = r_state == S_RUN;
    assign o_done = r_state == S_DONE;
    assign o_fail = r_fail;
    assign o_pat_cnt = r_pat_cnt;
    assign o_mismatch_cnt = r_mis_cnt;
    assign o_first_fail_idx = r_ff_idx;
    assign o_signature = r_sig;
endmodule

// File: doc/atpg_response_checker.md
Name: atpg_response_checker

Overview:
- Observing end of the fault-injection ATPG flow: samples the injection target's output alongside a golden (fault-free) output, one beat per applied pattern.
- Counts patterns and mismatches, records the index of the first failing pattern, and compacts the observed responses into a MISR signature.
- Sits beside the pattern applier that drives the injection module inputs; its results close the detect/no-detect verdict for each injected fault.

Parameters:
- N_OUT, 1, width of observed output vector (1 <= N_OUT <= MISR_W)
- CNT_W, 16, width of pattern/mismatch counters and first-fail index
- MISR_W, 16, signature register width
- MISR_POLY, 16'h1021, feedback polynomial taps (MISR_W bits)
- MISR_SEED, 16'hFFFF, signature value loaded on start

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new check session (one-cycle pulse)
- pat_valid  in  1  dut_y/gold_y hold a valid response beat this cycle
- pat_last  in  1  qualifies the final beat of the session (meaningful only with pat_valid)
- dut_y  in  N_OUT  observed output of the fault-injected module
- gold_y  in  N_OUT  expected fault-free output
- busy  out  1  session in progress (state RUN)
- done  out  1  session complete, results stable
- fail  out  1  at least one mismatch in the session
- pat_cnt  out  CNT_W  beats accepted this session
- mismatch_cnt  out  CNT_W  mismatching beats this session
- first_fail_idx  out  CNT_W  0-based index of first mismatching beat
- signature  out  MISR_W  MISR compaction of dut_y

Behaviour:
- Reset: state IDLE; busy=0, done=0, fail=0, pat_cnt=0, mismatch_cnt=0, first_fail_idx=0, signature=0 (not the seed). Reset overrides all other inputs, including mid-session.
- All outputs are registered and update on the edge that samples the causing input (visible one cycle after the input beat).
- States: IDLE, RUN, DONE.
- IDLE --start--> RUN. Entry clears the counters, first_fail_idx and fail, and loads signature=MISR_SEED.
- DONE --start--> RUN, with the same clearing; the previous results are overwritten.
- RUN ignores start. pat_valid is ignored in IDLE and DONE; nothing updates.
- Each RUN beat (pat_valid=1):
  - pat_cnt increments, saturating at 2^CNT_W-1.
  - mismatch = (dut_y != gold_y), comparing all N_OUT bits.
  - On mismatch, mismatch_cnt increments (saturating). If it is the first mismatch, first_fail_idx = the pat_cnt value before the increment. fail is set and stays set.
  - MISR update: sig_next = {sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended dut_y.
- pat_valid & pat_last in RUN: the beat is processed normally, then the state moves to DONE. Next cycle busy=0 and done=1, held until start or rst.
- pat_last without pat_valid: ignored.
- start and pat_valid in the same cycle from IDLE/DONE: only start acts; the beat is discarded.
- Once saturated, counters hold their value. first_fail_idx is frozen after the first capture.

Test Plan:
- N_OUT=1 defaults. Start, then 1 beat dut_y=1, gold_y=1, pat_last=1 -> next cycle signature=16'hEFDE, pat_cnt=1, mismatch_cnt=0, fail=0, done=1, busy=0.
- Start, then 4 beats with dut_y!=gold_y only on beat 2 (0-based), last on beat 3 -> pat_cnt=4, mismatch_cnt=1, first_fail_idx=2, fail=1, done 1 cycle after the beat-3 edge.
- CNT_W=4. Start, then 20 mismatching beats, last on the 20th -> pat_cnt=15, mismatch_cnt=15, first_fail_idx=0, fail=1.
- Start, then 3 beats (one mismatch), then rst high for 1 cycle mid-RUN -> all outputs 0, state IDLE. Beats while IDLE leave pat_cnt=0.
- During RUN, pulse start between beats -> no clear, counts continue. After DONE, start -> pat_cnt=0, fail=0, signature=16'hFFFF, busy=1, done=0 next cycle.
- In DONE, pat_valid=1 with mismatches for 5 cycles -> all results unchanged.
